// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
//   stage_rec_t   : per-stage instruction record tracked in EX/MEM/WB
//   ctrl_state_e  : controller FSM states
//   FWD_*         : EX operand forwarding select encodings
//   is_writer()   : record will architecturally write a non-zero register
package pipe_pkg;

  localparam int unsigned RA_W = 5;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            wr_en;
    logic            is_load;
  } stage_rec_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // x0 writes are discarded by the regfile, so they never need forwarding.
  function automatic logic is_writer(input stage_rec_t r);
    return r.valid && r.wr_en && (r.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// EX operand forwarding select for one source register.
//   rs      : source register of the EX instruction
//   mem_rec : record currently in MEM
//   wb_rec  : record currently in WB
//   sel_c   : FWD_MEM / FWD_WB / FWD_RF (combinational)
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  stage_rec_t      mem_rec,
  input  stage_rec_t      wb_rec,
  output logic [1:0]      sel_c
);

  // Youngest producer wins; a load in MEM has no result yet, so fall to WB.
  always_comb begin
    sel_c = FWD_RF;
    if (is_writer(mem_rec) && !mem_rec.is_load && (mem_rec.rd == rs)) begin
      sel_c = FWD_MEM;
    end else if (is_writer(wb_rec) && (wb_rec.rd == rs)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Tracks EX/MEM/WB records, raises load-use stalls, EX forwarding selects and
// ID write-back bypass flags, flushes on redirect, drains on halt, and counts
// retired instructions.
//   i_clk, i_rst (async, active low)
//   i_id_*        : decoded ID-stage instruction fields
//   i_ex_redirect : taken branch/jump resolved in EX
//   o_stall, o_flush, o_ex_bubble : pipeline control (combinational)
//   o_fwd_rs*_sel, o_id_byp_rs*   : operand source selects (combinational)
//   o_halted      : pipeline drained after halt
//   o_retire_count: instructions retired from WB (registered)
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_reg_wr_en,
  input  logic                  i_id_is_load,
  input  logic                  i_id_halt,
  input  logic                  i_ex_redirect,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic                  o_ex_bubble,
  output logic [1:0]            o_fwd_rs1_sel,
  output logic [1:0]            o_fwd_rs2_sel,
  output logic                  o_id_byp_rs1,
  output logic                  o_id_byp_rs2,
  output logic                  o_halted,
  output logic [CNT_W-1:0]      o_retire_count
);

  localparam int unsigned DC_W = $clog2(DRAIN_CYCLES + 1);

  stage_rec_t      ex_q, mem_q, wb_q;
  stage_rec_t      id_rec;
  ctrl_state_e     state_q, state_d;
  logic [DC_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic            load_use;
  logic            accept_halt;

  assign id_rs1 = RA_W'(i_id_rs1);
  assign id_rs2 = RA_W'(i_id_rs2);
  assign id_rd  = RA_W'(i_id_rd);

  // ID reads the destination of a load still in EX: data not ready for one cycle.
  assign load_use = i_id_valid && ex_q.is_load && is_writer(ex_q) &&
                    ((i_id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                     (i_id_uses_rs2 && (id_rs2 == ex_q.rd)));

  // The halt record still flows to WB (it retires) but must never write.
  always_comb begin
    id_rec.valid   = i_id_valid;
    id_rec.rd      = id_rd;
    id_rec.rs1     = id_rs1;
    id_rec.rs2     = id_rs2;
    id_rec.wr_en   = i_id_reg_wr_en && !accept_halt;
    id_rec.is_load = i_id_is_load;
  end

  // WB writes the regfile in the same cycle ID reads it.
  assign o_id_byp_rs1 = i_id_valid && i_id_uses_rs1 && is_writer(wb_q) && (id_rs1 == wb_q.rd);
  assign o_id_byp_rs2 = i_id_valid && i_id_uses_rs2 && is_writer(wb_q) && (id_rs2 == wb_q.rd);

  fwd_sel u_fwd_rs1 (
    .rs      (ex_q.rs1),
    .mem_rec (mem_q),
    .wb_rec  (wb_q),
    .sel_c   (o_fwd_rs1_sel)
  );

  fwd_sel u_fwd_rs2 (
    .rs      (ex_q.rs2),
    .mem_rec (mem_q),
    .wb_rec  (wb_q),
    .sel_c   (o_fwd_rs2_sel)
  );

  // Controller state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_stall     = 1'b0;
    o_flush     = 1'b0;
    o_ex_bubble = 1'b0;
    o_halted    = 1'b0;
    accept_halt = 1'b0;
    unique case (state_q)
      RUN: begin
        // Redirect squashes the stalled ID instruction, so no stall is needed.
        o_flush     = i_ex_redirect;
        o_ex_bubble = load_use || i_ex_redirect;
        o_stall     = load_use && !i_ex_redirect;
        if (i_id_valid && i_id_halt && !load_use && !i_ex_redirect) begin
          accept_halt = 1'b1;
          state_d     = DRAIN;
          cnt_d       = DC_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        // Halt is already past ID, so any redirect here is from older code.
        o_stall     = 1'b1;
        o_ex_bubble = 1'b1;
        if (cnt_q == DC_W'(1)) begin
          state_d = HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - DC_W'(1);
        end
      end
      HALTED: begin
        o_stall     = 1'b1;
        o_ex_bubble = 1'b1;
        o_halted    = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage records advance every cycle; the retire counter tracks WB.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ex_q           <= '0;
      mem_q          <= '0;
      wb_q           <= '0;
      o_retire_count <= '0;
    end else begin
      ex_q  <= o_ex_bubble ? stage_rec_t'('0) : id_rec;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (wb_q.valid) begin
        o_retire_count <= o_retire_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a stage-queue reference model predicts
// every cycle's outputs, a monitor compares them, plus directed spot checks.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_wr_en, id_is_load, id_halt;
  logic        ex_redirect;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall, flush, ex_bubble, byp1, byp2, halted;
  logic [1:0]  fwd1, fwd2;
  logic [31:0] retire_count;

  pipeline_ctrl #(.REG_ADDR_W(5), .CNT_W(32), .DRAIN_CYCLES(3)) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_id_valid     (id_valid),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_uses_rs1  (id_uses_rs1),
    .i_id_uses_rs2  (id_uses_rs2),
    .i_id_rd        (id_rd),
    .i_id_reg_wr_en (id_reg_wr_en),
    .i_id_is_load   (id_is_load),
    .i_id_halt      (id_halt),
    .i_ex_redirect  (ex_redirect),
    .o_stall        (stall),
    .o_flush        (flush),
    .o_ex_bubble    (ex_bubble),
    .o_fwd_rs1_sel  (fwd1),
    .o_fwd_rs2_sel  (fwd2),
    .o_id_byp_rs1   (byp1),
    .o_id_byp_rs2   (byp2),
    .o_halted       (halted),
    .o_retire_count (retire_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit we; bit ld; bit halt;
  } instr_t;

  typedef struct {
    bit v; int rd; int rs1; int rs2; bit we; bit ld;
  } rec_t;

  typedef struct packed {
    logic stall; logic flush; logic bub;
    logic [1:0] f1; logic [1:0] f2;
    logic b1; logic b2; logic halted;
    logic [31:0] ret;
  } exp_t;

  // Model: in-flight instructions by age (0=EX, 1=MEM, 2=WB).
  rec_t        pipe [3];
  int          since_halt;   // cycles since halt acceptance, -1 when none
  logic [31:0] retired;
  exp_t        sbq [$];
  bit          m_stall;
  int          total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t empty_rec();
    rec_t r;
    r.v = 0; r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.we = 0; r.ld = 0;
    return r;
  endfunction

  function automatic bit wr(input rec_t r);
    return r.v && r.we && (r.rd != 0);
  endfunction

  function automatic logic [1:0] fwd_of(input int rs);
    if (wr(pipe[1]) && !pipe[1].ld && pipe[1].rd == rs) return 2'b01;
    if (wr(pipe[2]) && pipe[2].rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic instr_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd,
                                bit we, bit ld, bit halt);
    instr_t i;
    i.v = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.rd = rd;
    i.we = we; i.ld = ld; i.halt = halt;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.v    = ($urandom % 8) != 0;
    i.rs1  = int'($urandom % 6);
    i.rs2  = int'($urandom % 6);
    i.rd   = int'($urandom % 6);
    i.u1   = ($urandom % 4) != 0;
    i.u2   = ($urandom % 2) != 0;
    i.we   = ($urandom % 4) != 0;
    i.ld   = ($urandom % 3) == 0;
    i.halt = ($urandom % 40) == 0;
    return i;
  endfunction

  // One cycle: drive ID inputs, predict outputs, push them, advance the model.
  task automatic step(input bit rn, input instr_t in, input bit redir);
    exp_t e;
    bit   lu, acc, drain, hlt;
    @(negedge clk);
    rst_n        = rn;
    id_valid     = rn && in.v;
    id_rs1       = rn ? 5'(in.rs1) : 5'd0;
    id_rs2       = rn ? 5'(in.rs2) : 5'd0;
    id_uses_rs1  = rn && in.u1;
    id_uses_rs2  = rn && in.u2;
    id_rd        = rn ? 5'(in.rd) : 5'd0;
    id_reg_wr_en = rn && in.we;
    id_is_load   = rn && in.ld;
    id_halt      = rn && in.halt;
    ex_redirect  = rn && redir;
    e = '0;
    if (!rn) begin
      for (int k = 0; k < 3; k++) pipe[k] = empty_rec();
      since_halt = -1;
      retired    = 32'd0;
      m_stall    = 0;
      sbq.push_back(e);
    end else begin
      drain = since_halt >= 1 && since_halt <= 3;
      hlt   = since_halt > 3;
      lu = in.v && wr(pipe[0]) && pipe[0].ld &&
           ((in.u1 && in.rs1 == pipe[0].rd) || (in.u2 && in.rs2 == pipe[0].rd));
      if (drain || hlt) begin
        e.stall = 1; e.bub = 1; e.flush = 0;
      end else begin
        e.flush = redir;
        e.stall = lu && !redir;
        e.bub   = lu || redir;
      end
      e.halted = hlt;
      e.f1  = fwd_of(pipe[0].rs1);
      e.f2  = fwd_of(pipe[0].rs2);
      e.b1  = in.v && in.u1 && wr(pipe[2]) && pipe[2].rd == in.rs1;
      e.b2  = in.v && in.u2 && wr(pipe[2]) && pipe[2].rd == in.rs2;
      e.ret = retired;
      sbq.push_back(e);
      m_stall = e.stall;
      acc = (since_halt < 0) && in.v && in.halt && !lu && !redir;
      if (pipe[2].v) retired = retired + 32'd1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (e.bub) pipe[0] = empty_rec();
      else begin
        pipe[0].v = in.v; pipe[0].rd = in.rd; pipe[0].rs1 = in.rs1;
        pipe[0].rs2 = in.rs2; pipe[0].we = in.we && !acc; pipe[0].ld = in.ld;
      end
      if (acc) since_halt = 1;
      else if (since_halt > 0) since_halt++;
    end
  endtask

  // Monitor: outputs are valid every cycle, compare once they settle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall",   32'(stall),        32'(e.stall));
        chk("flush",   32'(flush),        32'(e.flush));
        chk("bubble",  32'(ex_bubble),    32'(e.bub));
        chk("fwd_rs1", 32'(fwd1),         32'(e.f1));
        chk("fwd_rs2", 32'(fwd2),         32'(e.f2));
        chk("byp_rs1", 32'(byp1),         32'(e.b1));
        chk("byp_rs2", 32'(byp2),         32'(e.b2));
        chk("halted",  32'(halted),       32'(e.halted));
        chk("retire",  retire_count,      e.ret);
      end
    end
  end

  initial begin : stim
    instr_t nop, a, h, cur;
    bit     redir;
    int     w;
    total = 0; bad = 0; since_halt = -1; retired = 32'd0; m_stall = 0;
    for (int k = 0; k < 3; k++) pipe[k] = empty_rec();
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_reg_wr_en = 0; id_is_load = 0; id_halt = 0; ex_redirect = 0;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    h   = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);

    step(0, nop, 0); #1;
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    step(1, nop, 0);

    // lw x5 ; add x6,x5,x1
    step(1, mk(1, 1, 1, 0, 0, 5, 1, 1, 0), 0);
    a = mk(1, 5, 1, 1, 1, 6, 1, 0, 0);
    step(1, a, 0); #1;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_bubble", 32'(ex_bubble), 32'd1);
    step(1, a, 0); #1;
    chk("lu_release", 32'(stall), 32'd0);
    step(1, nop, 0); #1;
    chk("lu_fwd_wb", 32'(fwd1), 32'd2);

    // addi x3 ; sub x4,x3,x3
    step(1, mk(1, 2, 1, 0, 0, 3, 1, 0, 0), 0);
    step(1, mk(1, 3, 1, 3, 1, 4, 1, 0, 0), 0); #1;
    chk("alu_nostall", 32'(stall), 32'd0);
    step(1, nop, 0); #1;
    chk("mem_fwd_rs1", 32'(fwd1), 32'd1);
    chk("mem_fwd_rs2", 32'(fwd2), 32'd1);

    // x0 writer then x0 readers
    step(1, mk(1, 1, 1, 0, 0, 0, 1, 0, 0), 0);
    step(1, mk(1, 0, 1, 0, 1, 2, 1, 0, 0), 0);
    step(1, nop, 0); #1;
    chk("x0_fwd1", 32'(fwd1), 32'd0);
    chk("x0_fwd2", 32'(fwd2), 32'd0);
    step(1, mk(1, 0, 1, 0, 1, 2, 0, 0, 0), 0); #1;
    chk("x0_byp1", 32'(byp1), 32'd0);
    chk("x0_byp2", 32'(byp2), 32'd0);

    // WB write x7 while ID reads x7
    step(1, mk(1, 1, 1, 0, 0, 7, 1, 0, 0), 0);
    step(1, nop, 0);
    step(1, nop, 0);
    step(1, mk(1, 7, 1, 0, 0, 1, 1, 0, 0), 0); #1;
    chk("wb_byp1", 32'(byp1), 32'd1);

    // redirect coinciding with load-use
    step(1, mk(1, 0, 0, 0, 0, 9, 1, 1, 0), 0);
    step(1, mk(1, 9, 1, 0, 0, 10, 1, 0, 0), 1); #1;
    chk("redir_flush", 32'(flush), 32'd1);
    chk("redir_bubble", 32'(ex_bubble), 32'd1);
    chk("redir_stall", 32'(stall), 32'd0);

    // halt behind three older instructions; a redirect during drain is ignored
    step(0, nop, 0);
    step(1, nop, 0);
    step(1, mk(1, 1, 1, 2, 1, 11, 1, 0, 0), 0);
    step(1, mk(1, 1, 1, 2, 1, 12, 1, 0, 0), 0);
    step(1, mk(1, 1, 1, 2, 1, 13, 1, 0, 0), 0);
    step(1, h, 0); #1;
    chk("halt_acc_halted", 32'(halted), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1, nop, k == 2); #1;
      chk("drain_stall", 32'(stall), 32'd1);
      chk("drain_flush", 32'(flush), 32'd0);
      chk("drain_halted", 32'(halted), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("halt_retire", retire_count, 32'd4);
    step(1, nop, 0);

    // halt under load-use waits; halt under redirect is squashed
    step(0, nop, 0);
    step(1, nop, 0);
    step(1, mk(1, 0, 0, 0, 0, 5, 1, 1, 0), 0);
    step(1, mk(1, 5, 1, 0, 0, 0, 0, 0, 1), 0);
    step(1, mk(1, 5, 1, 0, 0, 0, 0, 0, 1), 0);
    for (int k = 0; k < 5; k++) step(1, nop, 0);
    step(0, nop, 0);
    step(1, nop, 0);
    step(1, h, 1);
    for (int k = 0; k < 5; k++) step(1, nop, 0);
    #1 chk("squash_halted", 32'(halted), 32'd0);

    // reset in the middle of a drain
    step(1, mk(1, 1, 1, 0, 0, 2, 1, 0, 0), 0);
    step(1, h, 0);
    step(1, nop, 0);
    step(0, nop, 0); #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_bubble", 32'(ex_bubble), 32'd0);
    chk("mid_rst_retire", retire_count, 32'd0);
    step(1, nop, 0); #1;
    chk("mid_rst_run", 32'(stall), 32'd0);

    // random epochs: ID instruction is held while stalled
    for (int ep = 0; ep < 8; ep++) begin
      step(0, nop, 0);
      step(1, nop, 0);
      cur = nop;
      for (int c = 0; c < 60; c++) begin
        if (!m_stall) cur = rand_instr();
        redir = ($urandom % 10) == 0;
        step(1, cur, redir);
      end
    end

    w = 0;
    while (sbq.size() > 0 && w < 10) begin
      @(negedge clk);
      #3;
      w++;
    end
    total++;
    if (sbq.size() > 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It sits beside instrDecode and does five jobs:
- tracks the destination/load state of the instructions in EX, MEM and WB;
- generates load-use stalls, EX operand forwarding selects and ID write-back bypass flags;
- flushes on taken branches/jumps;
- drains the pipeline on a halt instruction;
- counts retired instructions.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 32, retire counter width
DRAIN_CYCLES, 3, cycles from halt acceptance until EX/MEM/WB are empty

Ports:
i_clk  in  1  core clock
i_rst  in  1  asynchronous, active-low reset
i_id_valid  in  1  ID holds a valid instruction
i_id_rs1  in  REG_ADDR_W  rs1 of ID instruction
i_id_rs2  in  REG_ADDR_W  rs2 of ID instruction
i_id_uses_rs1  in  1  ID instruction reads rs1
i_id_uses_rs2  in  1  ID instruction reads rs2
i_id_rd  in  REG_ADDR_W  rd of ID instruction
i_id_reg_wr_en  in  1  ID instruction writes rd
i_id_is_load  in  1  ID instruction is a load
i_id_halt  in  1  ID instruction is halt (o_halt from decode)
i_ex_redirect  in  1  EX resolved taken branch/jump
o_stall  out  1  hold PC and IF/ID register
o_flush  out  1  squash IF/ID contents (write NOP)
o_ex_bubble  out  1  load NOP into ID/EX register
o_fwd_rs1_sel  out  2  EX rs1 source: 00 regfile, 01 MEM result, 10 WB data
o_fwd_rs2_sel  out  2  same for rs2
o_id_byp_rs1  out  1  ID rs1 takes i_reg_wr_data (WB same-cycle write)
o_id_byp_rs2  out  1  same for rs2
o_halted  out  1  pipeline drained after halt
o_retire_count  out  CNT_W  instructions retired from WB

Behaviour:
- Reset (i_rst=0, asynchronous): all stage records (valid, rd, wr_en, is_load, rs1, rs2) cleared; FSM=RUN; drain counter=0; o_retire_count=0; o_halted=0. All combinational outputs are therefore 0 / 00.
- Stage records: each clock, WB<=MEM, MEM<=EX, EX<=ID record when o_ex_bubble=0, else EX<=invalid.
- A record counts as a "writer" only if valid && wr_en && rd!=0.
- Load-use: load_use = i_id_valid && EX.valid && EX.is_load && EX writer && ((uses_rs1 && rs1==EX.rd) || (uses_rs2 && rs2==EX.rd)).
- Load-use response: o_stall=1 and o_ex_bubble=1 for exactly 1 cycle; the stalled instruction then resolves through WB forwarding.
- Forwarding per EX operand:
  - EX.rsN matches a MEM writer and MEM is not a load -> 01;
  - else matches a WB writer -> 10;
  - else 00.
  - MEM wins over WB. A MEM load cannot match, because load-use already inserted the bubble.
- ID bypass: o_id_byp_rsN = i_id_valid && uses_rsN && WB writer && rsN==WB.rd.
- Redirect: i_ex_redirect=1 -> o_flush=1 and o_ex_bubble=1 in the same cycle. Redirect overrides load-use (o_stall=0). The EX instruction itself continues.
- FSM states:
  - RUN: accept halt when i_id_valid && i_id_halt && !load_use && !i_ex_redirect. The halt record enters EX with wr_en=0. Then -> DRAIN, counter=DRAIN_CYCLES.
    - A halt coinciding with a redirect is squashed; stay RUN.
    - A halt coinciding with load-use waits one cycle.
  - DRAIN: o_stall=1, o_ex_bubble=1; counter decrements each cycle; at counter==1 -> HALTED. A redirect from an older branch in EX during DRAIN is ignored, because halt already passed ID.
  - HALTED: o_halted=1, o_stall=1, o_ex_bubble=1. Left only by reset.
- Retire: o_retire_count increments by 1 in each cycle WB.valid=1; wraps modulo 2^CNT_W. The halt record counts as retired.
- Outputs o_stall/o_flush/o_ex_bubble/fwd/byp are combinational from registered state and ID inputs; no added latency.
- Reset mid-DRAIN returns to RUN with empty stages.

Decomposition:
- Shared package pipe_pkg:
  - stage record typedef {valid, rd, rs1, rs2, wr_en, is_load};
  - FSM enum {RUN, DRAIN, HALTED};
  - forwarding select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
- One natural sub-module: fwd_sel, the combinational per-operand priority compare, instantiated twice for rs1 and rs2.

Test Plan:
- lw x5 then add x6,x5,x1 back-to-back -> one cycle with o_stall=1, o_ex_bubble=1. Next cycle the add enters EX with o_fwd_rs1_sel=10.
- addi x3 then sub x4,x3,x3 -> no stall. With sub in EX: o_fwd_rs1_sel=01, o_fwd_rs2_sel=01.
- Writer to x0 followed by a reader of x0 -> fwd selects 00 and byp flags 0. A WB write to x7 while ID reads x7 -> o_id_byp_rs1=1.
- i_ex_redirect=1 in the same cycle as a load-use -> o_flush=1, o_ex_bubble=1, o_stall=0.
- Halt in ID with 3 valid older instructions -> DRAIN for 3 cycles. o_halted=1 on the 4th cycle. o_retire_count increases by 4 (3 older instructions + halt).
- Assert i_rst low in DRAIN -> all outputs 0 immediately, o_retire_count=0, state RUN.
